// File: rtl/nibbler_display_scan.sv
// rtl/nibbler_display_scan.sv - 4-digit multiplexed seven-segment scanner for the Nibbler CPU outputs
// Snapshots ports/accumulator/flags once per frame; all outputs are registered from next-state values.
module nibbler_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 8,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] out_0,
  input  logic [3:0] out_1,
  input  logic [3:0] out_2,
  input  logic [3:0] a_val,
  input  logic       carry,
  input  logic       zero,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       led_carry,
  output logic       led_zero,
  output logic       frame_tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam bit NO_BLANK = (BLANK_CYCLES == 0);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = NO_BLANK ? '0 : CW'(BLANK_CYCLES - 1);
  localparam logic INV = COMMON_ANODE;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  typedef struct packed {
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       c;
    logic       z;
  } snap_t;

  state_t        state, state_d;
  logic [1:0]    slot, slot_d;
  logic [CW-1:0] cnt, cnt_d;
  snap_t         snap, snap_d, live;

  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;
  logic       tick_d;
  logic [3:0] nib;
  logic       lit;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  assign live = '{d0: out_0, d1: out_1, d2: out_2, d3: a_val, c: carry, z: zero};

  always_comb begin
    state_d = state;
    slot_d  = slot;
    cnt_d   = cnt;
    snap_d  = snap;
    if (!enable) begin
      state_d = IDLE;
      slot_d  = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          snap_d  = live;
          slot_d  = 2'd0;
          cnt_d   = '0;
          state_d = NO_BLANK ? SHOW : BLANK;
        end
        BLANK: begin
          cnt_d = cnt + CW'(1);
          if (cnt == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_d   = '0;
            slot_d  = slot + 2'd1;
            state_d = NO_BLANK ? SHOW : BLANK;
            // Frame boundary: every digit of the next frame uses this capture.
            if (slot == 2'd3) snap_d = live;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    case (slot_d)
      2'd0:    nib = snap_d.d0;
      2'd1:    nib = snap_d.d1;
      2'd2:    nib = snap_d.d2;
      default: nib = snap_d.d3;
    endcase
    lit    = (state_d == SHOW);
    an_d   = lit ? (4'b0001 << slot_d) : 4'b0000;
    seg_d  = lit ? hex7(nib) : 7'b0000000;
    dp_d   = lit && (((slot_d == 2'd3) && snap_d.c) || ((slot_d == 2'd0) && snap_d.z));
    tick_d = lit && (slot_d == 2'd3) && (cnt_d == SHOW_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      slot       <= 2'd0;
      cnt        <= '0;
      snap       <= '0;
      an         <= {4{INV}};
      seg        <= {7{INV}};
      dp         <= INV;
      frame_tick <= 1'b0;
      led_carry  <= 1'b0;
      led_zero   <= 1'b0;
    end else begin
      state      <= state_d;
      slot       <= slot_d;
      cnt        <= cnt_d;
      snap       <= snap_d;
      an         <= an_d ^ {4{INV}};
      seg        <= seg_d ^ {7{INV}};
      dp         <= dp_d ^ INV;
      frame_tick <= tick_d;
      led_carry  <= carry;
      led_zero   <= zero;
    end
  end

endmodule

// File: tb/tb_nibbler_display_scan.sv
// tb/tb_nibbler_display_scan.sv - scoreboard bench for nibbler_display_scan
// Two instances share stimulus: blanking of 2 cycles and no blanking.
module tb_nibbler_display_scan;

  logic       clk = 1'b0;
  logic       reset, enable, carry, zero;
  logic [3:0] out_0, out_1, out_2, a_val;
  logic [6:0] seg, seg0;
  logic [3:0] an, an0;
  logic       dp, dp0, led_carry, led_zero, led_carry0, led_zero0, frame_tick, frame_tick0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  nibbler_display_scan #(.SCAN_DIV(10), .BLANK_CYCLES(2), .COMMON_ANODE(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .out_0(out_0), .out_1(out_1), .out_2(out_2),
    .a_val(a_val), .carry(carry), .zero(zero), .seg(seg), .dp(dp), .an(an),
    .led_carry(led_carry), .led_zero(led_zero), .frame_tick(frame_tick));

  nibbler_display_scan #(.SCAN_DIV(10), .BLANK_CYCLES(0), .COMMON_ANODE(1'b1)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .out_0(out_0), .out_1(out_1), .out_2(out_2),
    .a_val(a_val), .carry(carry), .zero(zero), .seg(seg0), .dp(dp0), .an(an0),
    .led_carry(led_carry0), .led_zero(led_zero0), .frame_tick(frame_tick0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'h3f; 4'h1: seg_of = 7'h06; 4'h2: seg_of = 7'h5b; 4'h3: seg_of = 7'h4f;
      4'h4: seg_of = 7'h66; 4'h5: seg_of = 7'h6d; 4'h6: seg_of = 7'h7d; 4'h7: seg_of = 7'h07;
      4'h8: seg_of = 7'h7f; 4'h9: seg_of = 7'h6f; 4'hA: seg_of = 7'h77; 4'hB: seg_of = 7'h7c;
      4'hC: seg_of = 7'h39; 4'hD: seg_of = 7'h5e; 4'hE: seg_of = 7'h79; default: seg_of = 7'h71;
    endcase
  endfunction

  function automatic exp_t dark();
    dark = '{an: 4'hf, seg: 7'h7f, dp: 1'b1, tick: 1'b0};
  endfunction

  // One frame of expected cycles, starting with the cycle after the capturing edge.
  task automatic push_frame(input logic [3:0] d0, d1, d2, d3, input logic c, z,
                            input int blank, input bit to_q0);
    logic [3:0] d;
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      d = (s == 0) ? d0 : (s == 1) ? d1 : (s == 2) ? d2 : d3;
      for (int k = 0; k < 10; k++) begin
        if (k < blank) e = dark();
        else begin
          e.an   = ~(4'b0001 << s);
          e.seg  = ~seg_of(d);
          e.dp   = ~(((s == 3) && c) || ((s == 0) && z));
          e.tick = (s == 3) && (k == 9);
        end
        if (to_q0) q0.push_back(e);
        else q.push_back(e);
      end
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", 32'(an), 32'(e.an));
      chk("seg", 32'(seg), 32'(e.seg));
      chk("dp", 32'(dp), 32'(e.dp));
      chk("tick", 32'(frame_tick), 32'(e.tick));
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("an_nb", 32'(an0), 32'(e.an));
      chk("seg_nb", 32'(seg0), 32'(e.seg));
      chk("dp_nb", 32'(dp0), 32'(e.dp));
      chk("tick_nb", 32'(frame_tick0), 32'(e.tick));
    end
  endtask

  task automatic check_dark_reset(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hf);
    chk({tag, "_seg"}, 32'(seg), 32'h7f);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
    chk({tag, "_lc"}, 32'(led_carry), 32'h0);
    chk({tag, "_lz"}, 32'(led_zero), 32'h0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; carry = 1'b0; zero = 1'b0;
    out_0 = 4'h0; out_1 = 4'h0; out_2 = 4'h0; a_val = 4'h0;
    #12;
    check_dark_reset("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // Frame 1: 0 8 A F, no flags.
    out_0 = 4'h0; out_1 = 4'h8; out_2 = 4'hA; a_val = 4'hF;
    enable = 1'b1;
    push_frame(4'h0, 4'h8, 4'hA, 4'hF, 1'b0, 1'b0, 2, 1'b0);
    for (int i = 0; i < 25; i++) step();

    // Mid slot 2: new out_1 and flags must wait for the next frame.
    out_1 = 4'h3; carry = 1'b1; zero = 1'b1;
    push_frame(4'h0, 4'h3, 4'hA, 4'hF, 1'b1, 1'b1, 2, 1'b0);
    step();
    chk("led_carry", 32'(led_carry), 32'h1);
    chk("led_zero", 32'(led_zero), 32'h1);
    for (int i = 0; i < 29; i++) step();

    // Frame 2 slot 1 SHOW: drop enable, dark from the next cycle.
    enable = 1'b0;
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(dark());
    for (int i = 0; i < 5; i++) step();

    // Re-enable with fresh values; both instances start together.
    out_0 = 4'h1; out_1 = 4'h2; out_2 = 4'h4; a_val = 4'h7; carry = 1'b0; zero = 1'b1;
    enable = 1'b1;
    push_frame(4'h1, 4'h2, 4'h4, 4'h7, 1'b0, 1'b1, 2, 1'b0);
    push_frame(4'h1, 4'h2, 4'h4, 4'h7, 1'b0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 40; i++) step();

    // Inputs change in the last cycle of the frame: captured at the frame edge.
    out_0 = 4'hE; out_1 = 4'hD; out_2 = 4'hC; a_val = 4'hB; carry = 1'b1; zero = 1'b0;
    push_frame(4'hE, 4'hD, 4'hC, 4'hB, 1'b1, 1'b0, 2, 1'b0);
    push_frame(4'hE, 4'hD, 4'hC, 4'hB, 1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 15; i++) step();

    // Asynchronous reset while slot 1 is lit.
    chk("pre_rst_lc", 32'(led_carry), 32'h1);
    reset = 1'b1;
    q.delete();
    q0.delete();
    #1;
    check_dark_reset("arst");
    step();
    reset = 1'b0;
    enable = 1'b0;
    step();
    chk("idle_an", 32'(an), 32'hf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
